// File: rtl/garage_door_pkg.sv
// Shared types and constants for the garage door supervisor.
// State encoding, direction values and requester indices.
package garage_door_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDwell = 3'd1,
        StMvUp  = 3'd2,
        StMvDn  = 3'd3,
        StFault = 3'd4
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int unsigned REQ_BTN = 0;
    localparam int unsigned REQ_RMT = 1;

endpackage

// File: rtl/garage_door_supervisor_if.sv
// Door I/O bundle between the door hardware side (master) and the supervisor (slave).
interface garage_door_supervisor_if;

    logic       btn_req;
    logic       rmt_req;
    logic       up_max;
    logic       dn_max;
    logic       obstruct;
    logic       fault_clr;
    logic       up_motor;
    logic       dn_motor;
    logic       busy;
    logic       fault;
    logic       last_dir;
    logic [1:0] grant;

    modport master (
        output btn_req, rmt_req, up_max, dn_max, obstruct, fault_clr,
        input  up_motor, dn_motor, busy, fault, last_dir, grant
    );

    modport slave (
        input  btn_req, rmt_req, up_max, dn_max, obstruct, fault_clr,
        output up_motor, dn_motor, busy, fault, last_dir, grant
    );

endinterface

// File: rtl/garage_req_arb.sv
// Rising-edge detection of the two requesters with fixed btn > rmt priority.
// History resets high so a request held through reset is not an activation.
module garage_req_arb
    import garage_door_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_req,
    input  logic       i_rmt_req,
    output logic       o_act,
    output logic [1:0] o_grant_cand
);

    logic r_btn_prev;
    logic r_rmt_prev;
    logic w_btn_rise;
    logic w_rmt_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b1;
            r_rmt_prev <= 1'b1;
        end else begin
            r_btn_prev <= i_btn_req;
            r_rmt_prev <= i_rmt_req;
        end
    end

    assign w_btn_rise = i_btn_req & ~r_btn_prev;
    assign w_rmt_rise = i_rmt_req & ~r_rmt_prev;
    assign o_act      = w_btn_rise | w_rmt_rise;

    // A simultaneous rmt edge is dropped, not deferred.
    always_comb begin
        o_grant_cand          = 2'b00;
        o_grant_cand[REQ_BTN] = w_btn_rise;
        o_grant_cand[REQ_RMT] = w_rmt_rise & ~w_btn_rise;
    end

endmodule

// File: rtl/garage_door_supervisor.sv
// Garage door motor sequencer: dead-time before every start, stop/resume,
// auto-reverse on obstruction while closing, and latched travel/limit faults.
module garage_door_supervisor
    import garage_door_pkg::*;
#(
    parameter int unsigned DEADTIME_CYC   = 4,
    parameter int unsigned TRAVEL_MAX_CYC = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    garage_door_supervisor_if.slave        io_door
);

    localparam logic [CNT_W-1:0] DwellLast  = CNT_W'(DEADTIME_CYC - 1);
    localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX_CYC - 1);

    logic             w_act;
    logic [1:0]       w_grant_cand;
    logic             w_accept;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pending_dir;
    logic             w_pending_nxt;
    logic             r_last_dir;
    logic             w_last_nxt;

    logic             r_up_motor;
    logic             r_dn_motor;
    logic             r_busy;
    logic             r_fault;
    logic [1:0]       r_grant;

    garage_req_arb u_req_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_req    (io_door.btn_req),
        .i_rmt_req    (io_door.rmt_req),
        .o_act        (w_act),
        .o_grant_cand (w_grant_cand)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_pending_nxt = r_pending_dir;
        w_last_nxt    = r_last_dir;
        w_accept      = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                w_accept  = w_act;
                if (w_act) begin
                    if (io_door.up_max && io_door.dn_max) begin
                        w_state_nxt = StFault;
                    end else begin
                        w_state_nxt = StDwell;
                        if (io_door.dn_max)      w_pending_nxt = DIR_UP;
                        else if (io_door.up_max) w_pending_nxt = DIR_DN;
                        else                     w_pending_nxt = ~r_last_dir;
                    end
                end
            end
            StDwell: begin
                w_accept = w_act;
                if (w_act) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == DwellLast) begin
                    // Never start closing into a broken beam.
                    if (r_pending_dir == DIR_DN && io_door.obstruct) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = (r_pending_dir == DIR_UP) ? StMvUp : StMvDn;
                        w_last_nxt  = r_pending_dir;
                    end
                end
            end
            StMvUp: begin
                w_accept = w_act;
                if (io_door.up_max)          w_state_nxt = StIdle;
                else if (w_act)              w_state_nxt = StIdle;
                else if (r_cnt == TravelLast) w_state_nxt = StFault;
            end
            StMvDn: begin
                w_accept = w_act;
                if (io_door.dn_max) begin
                    w_state_nxt = StIdle;
                end else if (io_door.obstruct) begin
                    w_state_nxt   = StDwell;
                    w_pending_nxt = DIR_UP;
                end else if (w_act) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == TravelLast) begin
                    w_state_nxt = StFault;
                end
            end
            StFault: begin
                w_cnt_nxt = '0;
                if (io_door.fault_clr) w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_pending_dir <= DIR_DN;
            r_last_dir    <= DIR_DN;
            r_up_motor    <= 1'b0;
            r_dn_motor    <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_grant       <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pending_dir <= w_pending_nxt;
            r_last_dir    <= w_last_nxt;
            r_up_motor    <= (w_state_nxt == StMvUp);
            r_dn_motor    <= (w_state_nxt == StMvDn);
            r_busy        <= (w_state_nxt != StIdle) && (w_state_nxt != StFault);
            r_fault       <= (w_state_nxt == StFault);
            r_grant       <= w_accept ? w_grant_cand : 2'b00;
        end
    end

    assign io_door.up_motor = r_up_motor;
    assign io_door.dn_motor = r_dn_motor;
    assign io_door.busy     = r_busy;
    assign io_door.fault    = r_fault;
    assign io_door.last_dir = r_last_dir;
    assign io_door.grant    = r_grant;

endmodule
